axi_pkt_framer: RTL and testbench

Streaming framer placed directly downstream of the AXI-Stream packetizer. Wraps every tlast-delimited input packet with a header word before the payload and a trailer word after it: header carries sync pattern, source ID and sequence number; trailer carries word count and checksum. Output is fully registered. Payload runs at full throughput, and framing overhead is exactly two output beats per packet.

---
 rtl/axi_pkt_framer_if.sv | 28 ++
 rtl/axi_pkt_framer.sv | 93 +++++++++
 tb/tb_axi_pkt_framer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkt_framer_if.sv
// AXI-Stream style beat bundle shared by the framer input and output.
// Master drives the beat; slave drives tready back.
interface axi_pkt_framer_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (
        output tdata,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axi_pkt_framer.sv
// Wraps each tlast-delimited packet in a header (sync, source, sequence)
// and a trailer (word count, xor checksum) through one output register.
module axi_pkt_framer #(
    parameter int          DATA_W = 32,
    parameter int          USER_W = 8,
    parameter logic [7:0]  SRC_ID = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    axi_pkt_framer_if.slave  s,
    axi_pkt_framer_if.master m,
    output logic [7:0]       seq_num
);

    typedef enum logic [1:0] {
        IDLE,
        PAY,
        TRL
    } state_t;

    state_t            state;
    logic [15:0]       count;
    logic [15:0]       chk;
    logic              slot_free;
    logic [15:0]       fold;
    logic [15:0]       count_inc;
    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] trl;

    assign slot_free = !m.tvalid || m.tready;
    assign s.tready  = (state == PAY) && slot_free;
    assign fold      = s.tdata[31:16] ^ s.tdata[15:0];
    assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;

    // Bits above 31 of framing words stay zero for wide buses.
    always_comb begin
        hdr       = '0;
        hdr[31:0] = {16'hA55A, SRC_ID, seq_num};
        trl       = '0;
        trl[31:0] = {count, chk};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            m.tvalid <= 1'b0;
            m.tlast  <= 1'b0;
            m.tdata  <= '0;
            m.tuser  <= '0;
            seq_num  <= 8'd0;
            count    <= 16'd0;
            chk      <= 16'd0;
        end else if (slot_free) begin
            m.tvalid <= 1'b0;
            m.tlast  <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Header is launched on sight of data; the beat waits.
                    if (s.tvalid) begin
                        m.tdata  <= hdr;
                        m.tuser  <= '0;
                        m.tvalid <= 1'b1;
                        state    <= PAY;
                    end
                end
                PAY: begin
                    if (s.tvalid) begin
                        m.tdata  <= s.tdata;
                        m.tuser  <= s.tuser;
                        m.tvalid <= 1'b1;
                        count    <= count_inc;
                        chk      <= chk ^ fold;
                        if (s.tlast) begin
                            state <= TRL;
                        end
                    end
                end
                TRL: begin
                    m.tdata  <= trl;
                    m.tuser  <= '0;
                    m.tlast  <= 1'b1;
                    m.tvalid <= 1'b1;
                    seq_num  <= seq_num + 8'd1;
                    count    <= 16'd0;
                    chk      <= 16'd0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_pkt_framer.sv
// Bench for axi_pkt_framer: packet-level model feeding an expected-beat
// queue, one per-cycle compare process, plus literal spot checks.
module tb_axi_pkt_framer;

    localparam logic [7:0] SRC = 8'h3C;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  u;
        logic        l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] seq_num;

    axi_pkt_framer_if #(.DATA_W(32), .USER_W(8)) s_if ();
    axi_pkt_framer_if #(.DATA_W(32), .USER_W(8)) m_if ();

    axi_pkt_framer #(
        .DATA_W(32),
        .USER_W(8),
        .SRC_ID(SRC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s      (s_if.slave),
        .m      (m_if.master),
        .seq_num(seq_num)
    );

    always #5 clk = ~clk;

    int          vec = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          check_en = 1'b1;
    bit          rnd_ready = 1'b0;
    beat_t       exp_q[$];
    logic [31:0] obs_d[$];
    logic        obs_l[$];
    logic [7:0]  exp_seq = 8'd0;
    int          hs_cnt = 0;
    int          hs_first = -1;
    int          hs_last = -1;
    logic [31:0] tab[3];

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready changes just after the edge so it is stable at negedge.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: transfers against the model, stalls against last cycle.
    logic        prev_stall = 1'b0;
    logic [41:0] prev_out;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vec++;
                if ({m_if.tdata, m_if.tuser, m_if.tlast, m_if.tvalid} != prev_out) begin
                    bad++;
                    $display("FAIL stall_hold: got %h, want %h",
                             {m_if.tdata, m_if.tuser, m_if.tlast, m_if.tvalid}, prev_out);
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_out   = {m_if.tdata, m_if.tuser, m_if.tlast, m_if.tvalid};
            if (m_if.tvalid && m_if.tready) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
                obs_d.push_back(m_if.tdata);
                obs_l.push_back(m_if.tlast);
                if (check_en) begin
                    vec++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL beat: got d=%h u=%h l=%b, want no beat",
                                 m_if.tdata, m_if.tuser, m_if.tlast);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        if (m_if.tdata !== e.d || m_if.tuser !== e.u || m_if.tlast !== e.l) begin
                            bad++;
                            $display("FAIL beat: got d=%h u=%h l=%b, want d=%h u=%h l=%b",
                                     m_if.tdata, m_if.tuser, m_if.tlast, e.d, e.u, e.l);
                        end
                    end
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        vec++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] gen_d(int pid, int i);
        if (pid == 0) return tab[i];
        return 32'(pid) * 32'h9E3779B1 + 32'(i) * 32'h01013B7D;
    endfunction

    function automatic logic [7:0] gen_u(int pid, int i);
        return 8'(pid * 7 + i);
    endfunction

    // Frame model: header, payload verbatim, trailer with min(len,FFFF) and xor fold.
    task automatic model_pkt(int len, int pid);
        beat_t       b;
        logic [15:0] x;
        logic [31:0] w;
        int          n;
        x = 16'd0;
        b.d = {16'hA55A, SRC, exp_seq};
        b.u = 8'd0;
        b.l = 1'b0;
        exp_q.push_back(b);
        for (int i = 0; i < len; i++) begin
            w = gen_d(pid, i);
            x = x ^ w[31:16] ^ w[15:0];
            b.d = w;
            b.u = gen_u(pid, i);
            b.l = 1'b0;
            exp_q.push_back(b);
        end
        n = (len > 65535) ? 65535 : len;
        b.d = {n[15:0], x};
        b.u = 8'd0;
        b.l = 1'b1;
        exp_q.push_back(b);
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic put_beat(logic [31:0] d, logic [7:0] u, logic l);
        bit acc;
        int n;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 2000) begin
                $display("FAIL accept_timeout: got no s_tready, want accept within 2000 cycles");
                bad++;
                $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic send_pkt(int len, int pid);
        model_pkt(len, pid);
        for (int i = 0; i < len; i++) begin
            put_beat(gen_d(pid, i), gen_u(pid, i), i == len - 1);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            n++;
            if (n > 4000) begin
                $display("FAIL drain_timeout: got %0d beats pending, want 0", exp_q.size());
                bad++;
                $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
                $fatal(1, "timeout");
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_d.delete();
        obs_l.delete();
        hs_cnt   = 0;
        hs_first = -1;
        hs_last  = -1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_seq = 8'd0;
    endtask

    initial begin
        tab[0] = 32'h00010002;
        tab[1] = 32'h00030004;
        tab[2] = 32'h00050006;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b0;

        // Reset state
        #3;
        check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_tlast", 32'(m_if.tlast), 32'd0);
        check("rst_tdata", m_if.tdata, 32'd0);
        check("rst_tuser", 32'(m_if.tuser), 32'd0);
        check("rst_s_tready", 32'(s_if.tready), 32'd0);
        check("rst_seq", 32'(seq_num), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // 3-word packet, literal frame
        clear_obs();
        send_pkt(3, 0);
        drain();
        check("t1_beats", 32'(obs_d.size()), 32'd5);
        if (obs_d.size() == 5) begin
            check("t1_hdr", obs_d[0], 32'hA55A3C00);
            check("t1_w0", obs_d[1], 32'h00010002);
            check("t1_w2", obs_d[3], 32'h00050006);
            check("t1_trl", obs_d[4], 32'h00030007);
            check("t1_trl_last", 32'(obs_l[4]), 32'd1);
            check("t1_w2_last", 32'(obs_l[3]), 32'd0);
        end
        check("t1_seq", 32'(seq_num), 32'd1);

        // Two back-to-back 256-word packets, no bubbles
        clear_obs();
        fork
            begin
                send_pkt(256, 1);
                send_pkt(256, 2);
            end
        join
        drain();
        check("t2_beats", 32'(hs_cnt), 32'd516);
        check("t2_span", 32'(hs_last - hs_first + 1), 32'd516);
        if (obs_d.size() == 516) begin
            check("t2_hdr0_seq", 32'(obs_d[0][7:0]), 32'h01);
            check("t2_hdr1_seq", 32'(obs_d[258][7:0]), 32'h02);
            check("t2_trl0_cnt", 32'(obs_d[257][31:16]), 32'h0100);
            check("t2_trl1_cnt", 32'(obs_d[515][31:16]), 32'h0100);
        end

        // Random backpressure, random lengths
        rnd_ready = 1'b1;
        for (int p = 0; p < 20; p++) begin
            send_pkt(int'($urandom_range(1, 300)), 10 + p);
        end
        drain();
        rnd_ready = 1'b0;

        // 257 single-word packets from a fresh sequence
        pulse_reset();
        clear_obs();
        for (int p = 0; p < 257; p++) begin
            send_pkt(1, 40 + p);
        end
        drain();
        if (obs_d.size() == 771) begin
            check("t4_hdr257_seq", 32'(obs_d[768][7:0]), 32'h00);
            check("t4_hdr256_seq", 32'(obs_d[765][7:0]), 32'hFF);
            check("t4_trl_cnt", 32'(obs_d[770][31:16]), 32'h0001);
        end else begin
            check("t4_beats", 32'(obs_d.size()), 32'd771);
        end
        check("t4_seq", 32'(seq_num), 32'd1);

        // Reset after 10 accepted words of a packet
        check_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            put_beat(gen_d(500, i), gen_u(500, i), 1'b0);
        end
        rst = 1'b0;
        s_if.tvalid = 1'b0;
        #1;
        check("t5_tvalid", 32'(m_if.tvalid), 32'd0);
        check("t5_s_tready", 32'(s_if.tready), 32'd0);
        check("t5_seq", 32'(seq_num), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_seq  = 8'd0;
        clear_obs();
        check_en = 1'b1;
        send_pkt(5, 501);
        drain();
        check("t5_beats", 32'(obs_d.size()), 32'd7);
        if (obs_d.size() == 7) begin
            check("t5_hdr", obs_d[0], 32'hA55A3C00);
            check("t5_trl_cnt", 32'(obs_d[6][31:16]), 32'h0005);
        end

        // Saturating count on a 70000-word packet
        clear_obs();
        send_pkt(70000, 600);
        drain();
        if (obs_d.size() > 0) begin
            check("t6_trl_cnt", 32'(obs_d[obs_d.size() - 1][31:16]), 32'hFFFF);
            check("t6_trl_last", 32'(obs_l[obs_l.size() - 1]), 32'd1);
        end
        check("t6_beats", 32'(hs_cnt), 32'd70002);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
